body_renderer: RTL

BODY_RENDERER -- requirements
Module: body_renderer

---
 rtl/body_renderer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/body_renderer.sv
// Multi-body circle renderer: a double-buffered body table swapped on frame
// boundaries, feeding a 2-stage per-pixel "inside any circle" pipeline.

module body_lane #(
  parameter int COORD_W = 10,
  parameter int RAD_W   = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic               on,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [RAD_W-1:0]   r,
  output logic               hit
);
  localparam int SQ_W = 2*COORD_W + 1;

  logic [COORD_W-1:0] dx, dy;
  logic               on_q;
  logic [RAD_W-1:0]   r_q;
  logic [SQ_W-1:0]    dist2, rad2;

  // Stage 1 captures on/r with the distances so a swap cannot tear a pixel.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dx   <= '0;
      dy   <= '0;
      on_q <= 1'b0;
      r_q  <= '0;
    end else begin
      dx   <= (draw_x >= x) ? draw_x - x : x - draw_x;
      dy   <= (draw_y >= y) ? draw_y - y : y - draw_y;
      on_q <= on;
      r_q  <= r;
    end
  end

  assign dist2 = SQ_W'(dx) * SQ_W'(dx) + SQ_W'(dy) * SQ_W'(dy);
  assign rad2  = SQ_W'(r_q) * SQ_W'(r_q);
  assign hit   = on_q && (dist2 <= rad2);
endmodule

module body_renderer #(
  parameter int  N_BODIES = 8,
  parameter int  COORD_W  = 10,
  parameter int  RAD_W    = 5,
  localparam int ID_W     = (N_BODIES > 1) ? $clog2(N_BODIES) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               wr_en,
  input  logic [ID_W-1:0]    wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [RAD_W-1:0]   wr_r,
  input  logic               wr_on,
  output logic               wr_ready,
  output logic               wr_err,
  input  logic               commit,
  output logic               commit_pending,
  input  logic               VGA_VS,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               is_ball,
  output logic [ID_W-1:0]    ball_id,
  output logic               swap
);
  typedef struct packed {
    logic               on;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [RAD_W-1:0]   r;
  } body_t;

  localparam logic [ID_W:0] N_LIM = (ID_W+1)'(N_BODIES);

  body_t [N_BODIES-1:0] shadow, active;
  logic                 vs_q, vs_fall, do_swap, idx_ok;
  logic [N_BODIES-1:0]  hit;
  logic                 hit_any;
  logic [ID_W-1:0]      hit_id;

  assign vs_fall  = vs_q && !VGA_VS;
  assign do_swap  = vs_fall && (commit_pending || commit);
  assign wr_ready = !do_swap;
  assign idx_ok   = ({1'b0, wr_idx} < N_LIM);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow         <= '0;
      active         <= '0;
      commit_pending <= 1'b0;
      swap           <= 1'b0;
      wr_err         <= 1'b0;
      vs_q           <= 1'b1;
    end else begin
      vs_q   <= VGA_VS;
      swap   <= do_swap;
      wr_err <= wr_en && wr_ready && !idx_ok;
      if (wr_en && wr_ready && idx_ok)
        shadow[wr_idx] <= body_t'{wr_on, wr_x, wr_y, wr_r};
      if (do_swap) begin
        active         <= shadow;
        commit_pending <= 1'b0;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_BODIES; g++) begin : g_lane
    body_lane #(.COORD_W(COORD_W), .RAD_W(RAD_W)) u_lane (
      .Clk    (Clk),
      .Reset  (Reset),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .on     (active[g].on),
      .x      (active[g].x),
      .y      (active[g].y),
      .r      (active[g].r),
      .hit    (hit[g])
    );
  end

  // Walk downward so the lowest-indexed hit is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_id  = '0;
    for (int i = N_BODIES-1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_id  = ID_W'(i);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_ball <= 1'b0;
      ball_id <= '0;
    end else begin
      is_ball <= hit_any;
      ball_id <= hit_any ? hit_id : '0;
    end
  end
endmodule
